// File: rtl/au_cmd_sequencer.sv
// Command sequencer for an external combinational 8-bit AU: accumulator, carry, single-pass ops and an 8-pass shift-add MUL.
// Optional rsp_zero output is enabled by defining AU_CMD_SEQ_ZERO_FLAG_EN.
module au_cmd_sequencer #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] ACC_RST = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_cout,
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
    output logic              rsp_zero,
`endif
    output logic [DATA_W-1:0] au_x,
    output logic [DATA_W-1:0] au_y,
    output logic              au_s1,
    output logic              au_s0,
    output logic              au_cin,
    input  logic [DATA_W-1:0] au_f,
    input  logic              au_cout
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        op_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] acc;
    logic              carry;
    logic [DATA_W-1:0] mul_m, mul_q, mul_p, mul_sum;
    logic              mul_c, mul_c_nxt;
    logic [2:0]        pass_cnt;
    logic [2:0]        code;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_cout_r;
    logic              res_load;
    logic [DATA_W-1:0] res_data;
    logic              res_cout;
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
    logic              rsp_zero_r;
`endif

    // A pass only adds when the current multiplier bit is set; otherwise the partial product is held.
    assign mul_sum   = mul_q[0] ? au_f : mul_p;
    assign mul_c_nxt = mul_c | (mul_q[0] & au_cout);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        au_x      = acc;
        au_y      = '0;
        code      = 3'b000;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = (cmd_op == 4'd9) ? MUL : EXEC;
            end
            EXEC: begin
                if (!op_r[3]) begin
                    au_y = data_r;
                    code = op_r[2:0];
                end
                state_nxt = RESP;
            end
            MUL: begin
                au_x = mul_p;
                au_y = mul_m;
                code = mul_q[0] ? 3'b010 : 3'b000;
                if (pass_cnt == 3'd7)
                    state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
        endcase
    end

    assign au_s1  = code[2];
    assign au_s0  = code[1];
    assign au_cin = code[0];

    // Result of the command finishing this cycle; LOAD bypasses the AU, illegal ops echo acc with carry set.
    always_comb begin
        res_load = 1'b0;
        res_data = acc;
        res_cout = carry;
        if (state == EXEC) begin
            res_load = 1'b1;
            if (!op_r[3]) begin
                res_data = au_f;
                res_cout = au_cout;
            end else if (op_r == 4'd8) begin
                res_data = data_r;
                res_cout = 1'b0;
            end else begin
                res_data = acc;
                res_cout = 1'b1;
            end
        end else if (state == MUL && pass_cnt == 3'd7) begin
            res_load = 1'b1;
            res_data = mul_sum;
            res_cout = mul_c_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= ACC_RST;
            carry      <= 1'b0;
            rsp_data_r <= '0;
            rsp_cout_r <= 1'b0;
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
            rsp_zero_r <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (res_load) begin
                acc        <= res_data;
                carry      <= res_cout;
                rsp_data_r <= res_data;
                rsp_cout_r <= res_cout;
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
                rsp_zero_r <= (res_data == '0);
`endif
            end
        end
    end

    // Command capture and MUL working registers; every field is initialised at accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            op_r     <= cmd_op;
            data_r   <= cmd_data;
            mul_m    <= acc;
            mul_q    <= cmd_data;
            mul_p    <= '0;
            mul_c    <= 1'b0;
            pass_cnt <= 3'd0;
        end else if (state == MUL) begin
            mul_p    <= mul_sum;
            mul_c    <= mul_c_nxt;
            mul_m    <= mul_m << 1;
            mul_q    <= mul_q >> 1;
            pass_cnt <= pass_cnt + 3'd1;
        end
    end

    assign rsp_data = rsp_data_r;
    assign rsp_cout = rsp_cout_r;
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
    assign rsp_zero = rsp_zero_r;
`endif

endmodule

// File: tb/tb_au_cmd_sequencer.sv
// Randomized self-checking bench for au_cmd_sequencer with a behavioural AU and command-level reference model.
module tb_au_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_cout;
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
    logic       rsp_zero;
`endif
    logic [7:0] au_x, au_y, au_f;
    logic       au_s1, au_s0, au_cin, au_cout;
    logic [8:0] au_res;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] m_acc;

    au_cmd_sequencer #(.DATA_W(8), .ACC_RST(8'h00)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
        .rsp_zero(rsp_zero),
`endif
        .au_x(au_x), .au_y(au_y), .au_s1(au_s1), .au_s0(au_s0), .au_cin(au_cin),
        .au_f(au_f), .au_cout(au_cout)
    );

    always #5 clk = ~clk;

    // External AU: adder with inverted-y subtraction, as the hardware would build it.
    always_comb begin
        case ({au_s1, au_s0, au_cin})
            3'b000:  au_res = {1'b0, au_x};
            3'b001:  au_res = {1'b0, au_x} + 9'd1;
            3'b010:  au_res = {1'b0, au_x} + {1'b0, au_y};
            3'b011:  au_res = {1'b0, au_x} + {1'b0, au_y} + 9'd1;
            3'b100:  au_res = {1'b0, au_x} + {1'b0, ~au_y} + 9'd1;
            3'b101:  au_res = {1'b0, au_x} + {1'b0, ~au_y};
            3'b110:  au_res = {1'b0, au_x} + 9'h0FF;
            default: au_res = {1'b0, au_y};
        endcase
    end
    assign au_f    = au_res[7:0];
    assign au_cout = au_res[8];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {cout, result} of a command from plain integer arithmetic.
    function automatic logic [8:0] ref_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        int p;
        bit c;
        case (op)
            4'd0: return {1'b0, a};
            4'd1: begin s = int'(a) + 1;         return {s > 255, 8'(s)}; end
            4'd2: begin s = int'(a) + int'(b);     return {s > 255, 8'(s)}; end
            4'd3: begin s = int'(a) + int'(b) + 1; return {s > 255, 8'(s)}; end
            4'd4: begin s = int'(a) - int'(b);     return {s >= 0, 8'(s)}; end
            4'd5: begin s = int'(a) - int'(b) - 1; return {s >= 0, 8'(s)}; end
            4'd6: begin s = int'(a) - 1;           return {s >= 0, 8'(s)}; end
            4'd7: return {1'b0, b};
            4'd8: return {1'b0, b};
            4'd9: begin
                p = 0;
                c = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (b[i]) begin
                        s = p + ((int'(a) << i) % 256);
                        c = c | (s > 255);
                        p = s % 256;
                    end
                end
                if (p != (int'(a) * int'(b)) % 256) $display("model inconsistency");
                return {c, 8'(p)};
            end
            default: return {1'b1, a};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [7:0] d, input int hold, input bit keep_valid);
        logic [8:0] e;
        int lat;
        bit rdy_seen;
        e = ref_cmd(op, m_acc, d);
        check_val("idle_ready", cmd_ready, 1);
        check_val("idle_au", {au_x, au_y, au_s1, au_s0, au_cin}, {m_acc, 8'h00, 3'b000});
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick();
        if (keep_valid) cmd_data = 8'($urandom);
        else            cmd_valid = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (!rsp_valid && lat < 30) begin
            rdy_seen |= cmd_ready;
            tick();
            lat++;
        end
        check_val("latency", lat, (op == 4'd9) ? 9 : 2);
        check_val("busy_ready", rdy_seen, 0);
        if (rsp_valid) begin
            check_val("rsp_data", rsp_data, e[7:0]);
            check_val("rsp_cout", rsp_cout, e[8]);
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
            check_val("rsp_zero", rsp_zero, e[7:0] == 8'h00);
`endif
            for (int k = 0; k < hold; k++) begin
                tick();
                check_val("hold_rsp", {rsp_valid, cmd_ready, rsp_cout, rsp_data}, {1'b1, 1'b0, e[8], e[7:0]});
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            cmd_valid = 1'b0;
            check_val("post_hs", {rsp_valid, cmd_ready}, 2'b01);
        end
        m_acc = e[7:0];
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_acc = 8'h00;
    endtask

    initial begin
        bit vseen;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        reset_dut();
        check_val("rst_ready", cmd_ready, 1);
        check_val("rst_rsp", {rsp_valid, rsp_cout, rsp_data}, 10'h000);
        check_val("rst_au", {au_x, au_y, au_s1, au_s0, au_cin}, 19'h0);
`ifdef AU_CMD_SEQ_ZERO_FLAG_EN
        check_val("rst_zero", rsp_zero, 0);
`endif

        run_cmd(4'd8, 8'h0A, 0, 1'b0);
        run_cmd(4'd2, 8'h08, 0, 1'b0);
        check_val("add_result", m_acc, 8'h12);
        run_cmd(4'd8, 8'hFF, 0, 1'b0);
        run_cmd(4'd1, 8'h00, 1, 1'b0);
        run_cmd(4'd8, 8'h0A, 0, 1'b0);
        run_cmd(4'd4, 8'h08, 0, 1'b0);
        run_cmd(4'd4, 8'h05, 0, 1'b0);
        run_cmd(4'd8, 8'h0D, 0, 1'b0);
        run_cmd(4'd9, 8'h0B, 0, 1'b0);
        check_val("mul_result", m_acc, 8'h8F);
        run_cmd(4'd12, 8'h33, 5, 1'b1);
        run_cmd(4'd3, 8'h70, 5, 1'b1);

        // Reset during MUL pass 4 must abandon the command.
        run_cmd(4'd8, 8'h37, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 4'd9;
        cmd_data  = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_acc = 8'h00;
        check_val("midrst_state", {rsp_valid, cmd_ready, rsp_data}, {2'b01, 8'h00});
        vseen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            vseen |= rsp_valid;
            tick();
        end
        check_val("midrst_no_rsp", vseen, 0);
        run_cmd(4'd0, 8'h5A, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            run_cmd(op, 8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        run_cmd(4'd8, 8'h00, 0, 1'b0);
        run_cmd(4'd6, 8'h00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
